// File: rtl/uart_rx_cfg.sv
// uart_rx_cfg: parametrised UART receiver with 3-sample majority vote and parity/framing/break flags
module uart_rx_cfg #(
  parameter int CLKS_PER_BIT = 87,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1,
  parameter int CNT_W        = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_rx_line,
  output logic                 o_rx_valid,
  output logic [DATA_BITS-1:0] o_rx_data,
  output logic                 o_parity_err,
  output logic                 o_frame_err,
  output logic                 o_break,
  output logic                 o_busy
);
  if (DATA_BITS < 5 || DATA_BITS > 9 || PARITY < 0 || PARITY > 2 ||
      STOP_BITS < 1 || STOP_BITS > 2 || CLKS_PER_BIT < 4) begin : g_bad_param
    $error("uart_rx_cfg: illegal parameter combination");
  end

  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF = CNT_W'((CLKS_PER_BIT - 1) / 2);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_WAIT_HIGH} state_t;

  state_t               state_q, state_d;
  logic [1:0]           sync_q;
  logic [2:0]           hist_q;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [3:0]           idx_q, idx_d;
  logic                 sidx_q, sidx_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 perr_q, perr_d, ferr_q, ferr_d;
  logic                 valid_q, valid_d, operr_q, operr_d, oferr_q, oferr_d, brk_q, brk_d;
  logic [DATA_BITS-1:0] odata_q, odata_d;
  logic                 vote, sample, ferr_now;

  assign vote     = (hist_q[0] & hist_q[1]) | (hist_q[0] & hist_q[2]) | (hist_q[1] & hist_q[2]);
  assign sample   = cnt_q == LAST;
  assign ferr_now = ferr_q | ~vote;

  // Two-flop synchroniser feeding the majority-vote history; idle-high after reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= 2'b11;
      hist_q <= 3'b111;
    end else begin
      sync_q <= {sync_q[0], i_rx_line};
      hist_q <= {hist_q[1:0], sync_q[1]};
    end
  end

  // Frame FSM: next state, bit counters, shift register and result loading
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CNT_W'(1);
    idx_d   = idx_q;
    sidx_d  = sidx_q;
    data_d  = data_q;
    perr_d  = perr_q;
    ferr_d  = ferr_q;
    valid_d = 1'b0;
    odata_d = odata_q;
    operr_d = operr_q;
    oferr_d = oferr_q;
    brk_d   = brk_q;
    unique case (state_q)
      S_IDLE: begin
        cnt_d   = '0;
        state_d = sync_q[1] ? S_IDLE : S_START;
      end
      S_START: if (cnt_q == HALF) begin
        cnt_d   = '0;
        idx_d   = '0;
        perr_d  = 1'b0;
        ferr_d  = 1'b0;
        state_d = vote ? S_IDLE : S_DATA;
      end
      S_DATA: if (sample) begin
        cnt_d  = '0;
        data_d = {vote, data_q[DATA_BITS-1:1]};
        idx_d  = idx_q + 4'd1;
        sidx_d = 1'b0;
        if (idx_q == 4'(DATA_BITS - 1)) state_d = (PARITY != 0) ? S_PARITY : S_STOP;
      end
      S_PARITY: if (sample) begin
        cnt_d   = '0;
        perr_d  = vote ^ (^data_q) ^ (PARITY == 1);
        state_d = S_STOP;
      end
      S_STOP: if (sample) begin
        cnt_d  = '0;
        ferr_d = ferr_now;
        sidx_d = sidx_q + 1'b1;
        if (sidx_q == 1'(STOP_BITS - 1)) begin
          valid_d = 1'b1;
          odata_d = data_q;
          operr_d = perr_q;
          oferr_d = ferr_now;
          brk_d   = ferr_now && data_q == '0;
          state_d = ferr_now ? S_WAIT_HIGH : S_IDLE;
        end
      end
      S_WAIT_HIGH: begin
        cnt_d   = '0;
        state_d = sync_q[1] ? S_IDLE : S_WAIT_HIGH;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers; reset discards any partial frame
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      sidx_q  <= 1'b0;
      data_q  <= '0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
      valid_q <= 1'b0;
      odata_q <= '0;
      operr_q <= 1'b0;
      oferr_q <= 1'b0;
      brk_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      sidx_q  <= sidx_d;
      data_q  <= data_d;
      perr_q  <= perr_d;
      ferr_q  <= ferr_d;
      valid_q <= valid_d;
      odata_q <= odata_d;
      operr_q <= operr_d;
      oferr_q <= oferr_d;
      brk_q   <= brk_d;
    end
  end

  assign o_rx_valid   = valid_q;
  assign o_rx_data    = odata_q;
  assign o_parity_err = operr_q;
  assign o_frame_err  = oferr_q;
  assign o_break      = brk_q;
  assign o_busy       = state_q != S_IDLE;
endmodule

// File: tb/tb_uart_rx_cfg.sv
// tb_uart_rx_cfg: directed checks of 8N1, 8E1 and 7O2 receivers at 16 clk per bit
module tb_uart_rx_cfg;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] line = 3'b111;
  logic [2:0] v, busy, pe, fe, bk;
  logic [7:0] d0, d1;
  logic [6:0] d2;
  int         ncmp = 0, nerr = 0;
  int         vcnt [3];
  logic [8:0] cd [3][8];
  logic [2:0] cf [3][8];

  always #5 clk = ~clk;

  uart_rx_cfg #(.CLKS_PER_BIT(16), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .CNT_W(16)) u_8n1 (
    .clk(clk), .rst_n(rst_n), .i_rx_line(line[0]), .o_rx_valid(v[0]), .o_rx_data(d0),
    .o_parity_err(pe[0]), .o_frame_err(fe[0]), .o_break(bk[0]), .o_busy(busy[0]));
  uart_rx_cfg #(.CLKS_PER_BIT(16), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .CNT_W(16)) u_8e1 (
    .clk(clk), .rst_n(rst_n), .i_rx_line(line[1]), .o_rx_valid(v[1]), .o_rx_data(d1),
    .o_parity_err(pe[1]), .o_frame_err(fe[1]), .o_break(bk[1]), .o_busy(busy[1]));
  uart_rx_cfg #(.CLKS_PER_BIT(16), .DATA_BITS(7), .PARITY(1), .STOP_BITS(2), .CNT_W(16)) u_7o2 (
    .clk(clk), .rst_n(rst_n), .i_rx_line(line[2]), .o_rx_valid(v[2]), .o_rx_data(d2),
    .o_parity_err(pe[2]), .o_frame_err(fe[2]), .o_break(bk[2]), .o_busy(busy[2]));

  // Record every valid pulse with its data and {parity, frame, break} flags
  always @(negedge clk) begin
    if (v[0]) begin cd[0][vcnt[0] & 7] = {1'b0, d0}; cf[0][vcnt[0] & 7] = {pe[0], fe[0], bk[0]}; vcnt[0]++; end
    if (v[1]) begin cd[1][vcnt[1] & 7] = {1'b0, d1}; cf[1][vcnt[1] & 7] = {pe[1], fe[1], bk[1]}; vcnt[1]++; end
    if (v[2]) begin cd[2][vcnt[2] & 7] = {2'b0, d2}; cf[2][vcnt[2] & 7] = {pe[2], fe[2], bk[2]}; vcnt[2]++; end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Drive one frame on line[sel]; gbit inverts one cycle mid-bit, cut stops after that many bits
  task automatic send(input int sel, input logic [8:0] dat, input int nb, input int par,
                      input bit pflip, input int ns, input int gbit, input int cut);
    logic [15:0] fr;
    int n;
    logic p;
    fr = '0;
    p = 1'b0;
    for (int i = 0; i < nb; i++) begin fr[1+i] = dat[i]; p = p ^ dat[i]; end
    n = 1 + nb;
    if (par != 0) begin fr[n] = p ^ (par == 1) ^ pflip; n++; end
    for (int i = 0; i < ns; i++) begin fr[n] = 1'b1; n++; end
    for (int i = 0; i < n && i < cut; i++)
      for (int c = 0; c < 16; c++) begin
        line[sel] = (i == gbit && c == 8) ? ~fr[i] : fr[i];
        @(negedge clk);
      end
  endtask

  initial begin
    idle(3);
    chk("rst_valid", 32'(v), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_flags", 32'({pe, fe, bk}), 0);
    chk("rst_data", 32'({d0, d1, d2}), 0);
    rst_n = 1'b1;
    idle(20);
    // back-to-back 8N1
    send(0, 9'hA5, 8, 0, 0, 1, -1, 99);
    send(0, 9'h3C, 8, 0, 0, 1, -1, 99);
    idle(32);
    chk("b2b_count", 32'(vcnt[0]), 2);
    chk("b2b_data0", 32'(cd[0][0]), 32'hA5);
    chk("b2b_data1", 32'(cd[0][1]), 32'h3C);
    chk("b2b_flags0", 32'(cf[0][0]), 0);
    chk("b2b_flags1", 32'(cf[0][1]), 0);
    // 8E1: wrong then correct parity bit
    send(1, 9'h03, 8, 2, 1, 1, -1, 99);
    idle(32);
    chk("even_bad_count", 32'(vcnt[1]), 1);
    chk("even_bad_data", 32'(cd[1][0]), 32'h03);
    chk("even_bad_flags", 32'(cf[1][0]), 32'b100);
    send(1, 9'h03, 8, 2, 0, 1, -1, 99);
    idle(32);
    chk("even_ok_count", 32'(vcnt[1]), 2);
    chk("even_ok_flags", 32'(cf[1][1]), 0);
    // start glitch rejected, then normal frame
    line[0] = 1'b0;
    idle(4);
    chk("glitch_busy_hi", 32'(busy[0]), 1);
    line[0] = 1'b1;
    idle(9);
    chk("glitch_busy_lo", 32'(busy[0]), 0);
    chk("glitch_no_valid", 32'(vcnt[0]), 2);
    send(0, 9'h55, 8, 0, 0, 1, -1, 99);
    idle(32);
    chk("after_glitch_count", 32'(vcnt[0]), 3);
    chk("after_glitch_data", 32'(cd[0][2]), 32'h55);
    // one-cycle glitch mid data bit 3
    send(0, 9'hFF, 8, 0, 0, 1, 4, 99);
    idle(32);
    chk("vote_count", 32'(vcnt[0]), 4);
    chk("vote_data", 32'(cd[0][3]), 32'hFF);
    chk("vote_flags", 32'(cf[0][3]), 0);
    // held break
    line[0] = 1'b0;
    idle(320);
    chk("break_count", 32'(vcnt[0]), 5);
    chk("break_data", 32'(cd[0][4]), 0);
    chk("break_flags", 32'(cf[0][4]), 32'b011);
    chk("break_wait_busy", 32'(busy[0]), 1);
    line[0] = 1'b1;
    idle(32);
    chk("break_release_busy", 32'(busy[0]), 0);
    chk("break_no_retrigger", 32'(vcnt[0]), 5);
    send(0, 9'h81, 8, 0, 0, 1, -1, 99);
    idle(32);
    chk("post_break_count", 32'(vcnt[0]), 6);
    chk("post_break_data", 32'(cd[0][5]), 32'h81);
    chk("post_break_flags", 32'(cf[0][5]), 0);
    // 7O2 reset mid-frame
    send(2, 9'h2A, 7, 1, 0, 2, -1, 4);
    chk("abort_busy_pre", 32'(busy[2]), 1);
    rst_n = 1'b0;
    idle(1);
    chk("abort_busy_rst", 32'(busy[2]), 0);
    chk("abort_out_rst", 32'({v[2], d2, pe[2], fe[2], bk[2]}), 0);
    line[2] = 1'b1;
    idle(2);
    rst_n = 1'b1;
    idle(40);
    chk("abort_no_valid", 32'(vcnt[2]), 0);
    send(2, 9'h2A, 7, 1, 0, 2, -1, 99);
    idle(32);
    chk("odd_count", 32'(vcnt[2]), 1);
    chk("odd_data", 32'(cd[2][0]), 32'h2A);
    chk("odd_flags", 32'(cf[2][0]), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule
